// File: rtl/count_down_timer_pkg.sv
// Shared definitions for the count-down timer: counter width and FSM state encodings.
package count_down_timer_pkg;

    localparam int LEN_COUNTER_DATA = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/count_down_timer_register.sv
// Loadable register with synchronous active-high clear; holds the count and the reload value.
module count_down_timer_register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
        end else if (ld) begin
            out <= in;
        end
    end

endmodule

// File: rtl/count_down_timer.sv
// Count-down timer: IDLE -> RUN -> DONE (one-cycle done pulse), priority abort > start > en.
// Define COUNT_DOWN_AUTO_RELOAD_EN for periodic mode: DONE reloads from the latched init value.
module count_down_timer
    import count_down_timer_pkg::*;
#(
    parameter int WORD_LENGTH = LEN_COUNTER_DATA
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WORD_LENGTH-1:0] init,
    input  logic                   en,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic [WORD_LENGTH-1:0] out
);

    state_t                 state_q, state_d;
    logic                   busy_q, done_q;
    logic                   count_ld;
    logic [WORD_LENGTH-1:0] count_d, count_q;

    count_down_timer_register #(.WIDTH(WORD_LENGTH)) u_count_reg (
        .clk (clk),
        .rst (rst),
        .ld  (count_ld),
        .in  (count_d),
        .out (count_q)
    );

`ifdef COUNT_DOWN_AUTO_RELOAD_EN
    logic                   reload_ld;
    logic [WORD_LENGTH-1:0] reload_q;

    assign reload_ld = start && !abort;

    count_down_timer_register #(.WIDTH(WORD_LENGTH)) u_reload_reg (
        .clk (clk),
        .rst (rst),
        .ld  (reload_ld),
        .in  (init),
        .out (reload_q)
    );
`endif

    always_comb begin
        state_d  = state_q;
        count_ld = 1'b0;
        count_d  = count_q;
        if (abort) begin
            state_d  = IDLE;
            count_ld = 1'b1;
            count_d  = '0;
        end else if (start) begin
            count_ld = 1'b1;
            count_d  = init;
            state_d  = (init == '0) ? DONE : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (en) begin
                        count_ld = 1'b1;
                        count_d  = (count_q > WORD_LENGTH'(1)) ? count_q - WORD_LENGTH'(1) : '0;
                        state_d  = (count_q > WORD_LENGTH'(1)) ? RUN : DONE;
                    end
                end
                DONE: begin
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
                    // The DONE cycle is the first cycle of the next period, so the
                    // reload lands one below init to keep the period at exactly init.
                    if (reload_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        count_ld = 1'b1;
                        count_d  = reload_q - WORD_LENGTH'(1);
                        state_d  = (reload_q == WORD_LENGTH'(1)) ? DONE : RUN;
                    end
`else
                    state_d = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = count_q;

endmodule
